sram_ifetch_buffer: RTL and testbench
=====================================

Name: sram_ifetch_buffer

Overview:
Instruction-fetch front end that drives the read-only port (port 1) of the 32x256 SRAM macro. It holds the fetch PC and issues one word read per cycle while buffer credit remains. It captures the macro's read data and presents instructions to the core through a valid/ready FIFO. A redirect input (branch/jump) flushes all buffered and in-flight fetches.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, >=2)
ADDR_WIDTH, 8, SRAM word-address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports:
clk  in  1  single clock; also drives SRAM clk1
rst_n  in  1  synchronous active-low reset
redirect_valid  in  1  load new fetch PC and flush
redirect_pc  in  32  new byte PC (bits [1:0] ignored, treated as 0)
csb1  out  1  SRAM port-1 chip select, active low
addr1  out  ADDR_WIDTH  SRAM port-1 word address = fetch_pc[ADDR_WIDTH+1:2]
dout1  in  DATA_WIDTH  SRAM port-1 read data
instr_valid  out  1  FIFO head valid
instr_ready  in  1  core accepts head
instr  out  DATA_WIDTH  head instruction
instr_pc  out  32  byte PC of head instruction

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n), sampled at posedge clk.
- Reset values: csb1=1, addr1=RESET_PC[ADDR_WIDTH+1:2], instr_valid=0, instr=0, instr_pc=0, fetch_pc=RESET_PC, FIFO count=0, inflight=0.
- Reset mid-operation: any in-flight read is discarded. A dout1 value arriving in the cycle after reset must not be pushed.
- SRAM timing: csb1/addr1 are sampled by the macro at posedge N; dout1 is valid before posedge N+1. The block captures dout1 at posedge N+1 only if inflight=1.
- Issue rule (combinational, registered outputs not required): csb1=0 iff rst_n=1, redirect_valid=0, and (count + inflight − pop) < DEPTH, where pop = instr_valid & instr_ready.
- On issue at posedge N:
  - inflight<=1
  - inflight_pc<=fetch_pc
  - fetch_pc<=fetch_pc+4 (32-bit wrap)
- No issue: inflight<=0, fetch_pc holds.
- Address wrap: addr1 follows fetch_pc bits, so word 255 is followed by word 0. Upper PC bits are carried in instr_pc unchanged.
- Capture: at posedge N+1 with inflight=1 and no redirect, push {dout1, inflight_pc} into the FIFO.
- FIFO: in-order. instr/instr_pc always reflect the head entry; instr_valid=(count!=0).
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push when full cannot occur by the credit rule. Verification asserts this.
  - Pop when empty is ignored.
- Redirect at posedge R (redirect_valid=1):
  - FIFO flushed (count<=0, instr_valid=0 from R).
  - Response of any read issued at R−1 dropped: inflight<=0, no push at R.
  - fetch_pc<=redirect_pc&~3.
  - csb1=1 during the redirect cycle. First new issue is in the cycle after R, so the first redirected instruction is valid at R+2.
  - An instr_ready in the redirect cycle completes no handshake.
- Steady state with instr_ready=1: one instruction per cycle after 2-cycle start-up latency (issue at reset release, valid next cycle).
- Back-pressure: with instr_ready=0, issue stops once count+inflight=DEPTH. No SRAM read is ever issued without a guaranteed FIFO slot.
- Port 0 of the macro is not driven by this block.

Test Plan:
- Preload mem[0..5]=32'h11,22,33,44,55,66; release reset with RESET_PC=0, instr_ready=1 -> csb1=0 from the first cycle; instr 0x11@pc0, 0x22@pc4, 0x33@pc8 on consecutive cycles starting 2 cycles after reset release.
- instr_ready=0 from reset -> exactly DEPTH=4 reads issued (addr1 0..3), csb1 then stays 1; raising ready drains 0x11,0x22,0x33,0x44, then fetch resumes at addr1=4 with no gaps or duplicates.
- Redirect to 0x0000_0010 while FIFO holds 3 entries and a read is in flight -> instr_valid=0 next cycle; stale data never appears; next instr is mem[4]=0x55 with instr_pc=0x10 at R+2.
- RESET_PC=32'h0000_03FC, mem[255]=0xAA, mem[0]=0x11 -> instr 0xAA@pc 0x3FC, then 0x11@pc 0x400 (addr1 wraps 255->0).
- Alternate instr_ready 1/0 each cycle for 20 cycles -> instruction sequence strictly sequential, never more than 4 outstanding, no push-on-full assertion.
- Assert rst_n=0 for one cycle while a read is in flight and FIFO holds 2 -> after reset, outputs at reset values; the first instruction is mem[RESET_PC>>2]; the in-flight word is never delivered.

Source files
------------

// File: rtl/sram_ifetch_if.sv
// Bus between the instruction-fetch buffer, the SRAM read port (port 1) and the core.
// The master modport is the fetch block; the slave modport is the SRAM/core side.
interface sram_ifetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           instr_pc;

    modport master (
        input  redirect_valid, redirect_pc, dout1, instr_ready,
        output csb1, addr1, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, dout1, instr_ready,
        input  csb1, addr1, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/sram_ifetch_buffer.sv
// Instruction-fetch front end: issues one SRAM word read per cycle while FIFO credit
// remains, captures the read data one cycle later and presents it through a valid/ready FIFO.
module sram_ifetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sram_ifetch_if.master bus
);
    localparam int CW = $clog2(DEPTH);

    logic [31:0]           fetch_pc_q;
    logic [31:0]           inflight_pc_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [31:0]           pc_q   [DEPTH];
    logic [CW-1:0]         rd_ptr_q;
    logic [CW-1:0]         wr_ptr_q;
    logic [CW:0]           count_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CW+1:0]         used;

    // A redirect cycle completes no handshake and drops the returning read.
    assign pop   = bus.instr_valid & bus.instr_ready & ~bus.redirect_valid;
    assign push  = inflight_q & ~bus.redirect_valid;
    // Credit counts both buffered entries and the read whose data arrives next cycle.
    assign used  = (CW+2)'(count_q) + (CW+2)'(inflight_q) - (CW+2)'(pop);
    assign issue = rst_ni & ~bus.redirect_valid & (used < (CW+2)'(DEPTH));

    assign bus.csb1        = ~issue;
    assign bus.addr1       = fetch_pc_q[ADDR_WIDTH+1:2];
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= bus.redirect_pc & ~32'h3;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + 32'd4;
            end
            if (push) begin
                data_q[wr_ptr_q] <= bus.dout1;
                pc_q[wr_ptr_q]   <= inflight_pc_q;
                wr_ptr_q         <= wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + CW'(1);
            end
            count_q <= count_q + (CW+1)'(push) - (CW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_sram_ifetch_buffer.sv
// Bench for sram_ifetch_buffer: SRAM behavioural model plus a queue-based reference of
// the expected instruction stream, driven by directed scenarios and a random phase.
module tb_sram_ifetch_buffer;
    localparam int          DEPTH = 4;
    localparam int          AW    = 8;
    localparam int          DW    = 32;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ifetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

    sram_ifetch_buffer #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (sif)
    );

    logic [DW-1:0] mem [256];

    // Port-1 read: address sampled at the edge, data valid until the next edge.
    // Unselected cycles return junk so a capture without a pending read is visible.
    always @(posedge clk) begin
        if (!sif.csb1) sif.dout1 <= mem[sif.addr1];
        else           sif.dout1 <= $urandom;
    end

    int checks = 0;
    int failures = 0;
    int issued_cnt = 0;
    int obs_out = 0;

    logic [31:0] mq [$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_fetch = RPC;
    bit          m_fresh = 1'b1;
    bit          m_known = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check, then advance the model.
    task automatic do_cycle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit ev, pop, iss;
        int used;
        rst_n              = rst;
        sif.instr_ready    = rdy;
        sif.redirect_valid = rv;
        sif.redirect_pc    = rpc;
        #1;
        ev   = (mq.size() != 0);
        pop  = ev && rdy && !rv;
        used = mq.size() + int'(m_infl) - int'(pop);
        iss  = rst && !rv && (used < DEPTH);
        if (m_known) begin
            chk("csb1", sif.csb1, !iss);
            chk("addr1", sif.addr1, m_fetch[AW+1:2]);
            chk("instr_valid", sif.instr_valid, ev);
            if (ev) begin
                chk("instr_pc", sif.instr_pc, mq[0]);
                chk("instr", sif.instr, mem[mq[0][AW+1:2]]);
            end else if (m_fresh) begin
                chk("instr_rst", sif.instr, 0);
                chk("instr_pc_rst", sif.instr_pc, 0);
            end
            if (!rst || rv) obs_out = 0;
            else obs_out = obs_out + int'(!sif.csb1) - int'(sif.instr_valid && rdy);
            chk("credit", obs_out <= DEPTH, 1);
        end
        if (!sif.csb1) issued_cnt++;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_infl  = 1'b0;
            m_fetch = RPC;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else if (rv) begin
            mq.delete();
            m_infl  = 1'b0;
            m_fetch = rpc & ~32'h3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) begin
                mq.push_back(m_infl_pc);
                m_fresh = 1'b0;
            end
            m_infl = iss;
            if (iss) begin
                m_infl_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) do_cycle(1'b1, rdy, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        mem[3] = 32'h44; mem[4] = 32'h55; mem[5] = 32'h66;
        mem[255] = 32'hAA;
        sif.instr_ready    = 1'b0;
        sif.redirect_valid = 1'b0;
        sif.redirect_pc    = '0;
        @(negedge clk);

        // Start-up with the core always ready
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        run(2, 1'b1);
        chk("t1_first", sif.instr, 32'h11);
        chk("t1_first_pc", sif.instr_pc, 32'h0);
        run(1, 1'b1);
        chk("t1_second", sif.instr, 32'h22);
        chk("t1_second_pc", sif.instr_pc, 32'h4);
        run(1, 1'b1);
        chk("t1_third", sif.instr, 32'h33);
        chk("t1_third_pc", sif.instr_pc, 32'h8);
        run(4, 1'b1);

        // Back-pressure from reset, then drain
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        issued_cnt = 0;
        run(8, 1'b0);
        chk("t2_issues", issued_cnt, DEPTH);
        chk("t2_csb1_idle", sif.csb1, 1'b1);
        chk("t2_head", sif.instr, 32'h11);
        run(10, 1'b1);

        // Redirect with 3 buffered and 1 in flight
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        run(4, 1'b0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0010);
        chk("t3_flushed", sif.instr_valid, 1'b0);
        run(2, 1'b1);
        chk("t3_valid", sif.instr_valid, 1'b1);
        chk("t3_instr", sif.instr, 32'h55);
        chk("t3_pc", sif.instr_pc, 32'h10);
        run(3, 1'b1);

        // Word-address wrap, upper PC bits carried through
        do_cycle(1'b1, 1'b1, 1'b1, 32'h1234_03FE);
        run(2, 1'b1);
        chk("t4_last", sif.instr, 32'hAA);
        chk("t4_last_pc", sif.instr_pc, 32'h1234_03FC);
        run(1, 1'b1);
        chk("t4_wrap", sif.instr, 32'h11);
        chk("t4_wrap_pc", sif.instr_pc, 32'h1234_0400);

        // Alternating ready
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'(i % 2), 1'b0, 32'h0);

        // Reset while a read is in flight and two entries are buffered
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        run(3, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        chk("t6_valid", sif.instr_valid, 1'b0);
        chk("t6_addr1", sif.addr1, RPC[AW+1:2]);
        chk("t6_csb1", sif.csb1, 1'b1);
        run(2, 1'b1);
        chk("t6_first", sif.instr, mem[RPC[AW+1:2]]);
        chk("t6_first_pc", sif.instr_pc, RPC);
        run(4, 1'b1);

        // Random ready, redirects and occasional resets
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 15) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
